// File: rtl/ldtu_pack_fsm_if.sv
// rtl/ldtu_pack_fsm_if.sv - sample/placement bundle between the LiTe-DTU packer and its user
//
// Purpose : groups the per-sample inputs and the registered placement/fallback
//           outputs of ldtu_pack_fsm.
// Ports   : master - drives sample_valid, baseline_flag, Orbit, fallback, Orbit_FB;
//                    observes placement and fallback outputs.
//           slave  - the packer; consumes inputs, drives out_valid, word_type, slot,
//                    word_end, flush, flush_type, flush_fill, header, fb_strobe,
//                    fb_lane, fb_bc0.
interface ldtu_pack_fsm_if #(
  parameter int CNT_W = 3
);
  logic             sample_valid;
  logic             baseline_flag;
  logic             Orbit;
  logic             fallback;
  logic             Orbit_FB;
  logic             out_valid;
  logic             word_type;
  logic [CNT_W-1:0] slot;
  logic             word_end;
  logic             flush;
  logic             flush_type;
  logic [CNT_W-1:0] flush_fill;
  logic             header;
  logic             fb_strobe;
  logic             fb_lane;
  logic             fb_bc0;

  modport master (
    output sample_valid, baseline_flag, Orbit, fallback, Orbit_FB,
    input  out_valid, word_type, slot, word_end, flush, flush_type, flush_fill,
           header, fb_strobe, fb_lane, fb_bc0
  );

  modport slave (
    input  sample_valid, baseline_flag, Orbit, fallback, Orbit_FB,
    output out_valid, word_type, slot, word_end, flush, flush_type, flush_fill,
           header, fb_strobe, fb_lane, fb_bc0
  );
endinterface

// File: rtl/ldtu_pack_fsm.sv
// rtl/ldtu_pack_fsm.sv - LiTe-DTU sample-packing controller with fallback cadence FSM
//
// Purpose : places each ADC sample into a baseline or signal output word, reports
//           slot, word completion, early word closure and BC0 headers; in fallback
//           mode runs a fixed-period raw-sample cadence with sticky BC0 capture.
// Ports   : CLK   - system clock
//           rst_b - asynchronous active-low reset
//           bus   - ldtu_pack_fsm_if slave modport (inputs and registered outputs)
module ldtu_pack_fsm #(
  parameter int BASE_PER_WORD = 5,
  parameter int SIG_PER_WORD  = 2,
  parameter int CNT_W         = 3,
  parameter int FB_PERIOD     = 2,
  parameter int FB_CNT_W      = 1
) (
  input  logic           CLK,
  input  logic           rst_b,
  ldtu_pack_fsm_if.slave bus
);

  // Word state folds {open, type} into one encoding; EMPTY means no word open.
  typedef enum logic [1:0] {
    W_EMPTY = 2'd0,
    W_BASE  = 2'd1,
    W_SIG   = 2'd2
  } wstate_t;

  localparam logic [CNT_W:0]    BASE_N  = (CNT_W+1)'(BASE_PER_WORD);
  localparam logic [CNT_W:0]    SIG_N   = (CNT_W+1)'(SIG_PER_WORD);
  localparam logic [FB_CNT_W-1:0] FB_LAST = FB_CNT_W'(FB_PERIOD - 1);

  wstate_t             state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                orbit_pend_q, orbit_pend_d;

  logic                out_valid_q, out_valid_d;
  logic                word_type_q, word_type_d;
  logic [CNT_W-1:0]    slot_q, slot_d;
  logic                word_end_q, word_end_d;
  logic                flush_q, flush_d;
  logic                flush_type_q, flush_type_d;
  logic [CNT_W-1:0]    flush_fill_q, flush_fill_d;
  logic                header_q, header_d;

  logic [FB_CNT_W-1:0] fb_cnt_q, fb_cnt_d;
  logic                fb_lane_q, fb_lane_d;
  logic                fb_sticky_q, fb_sticky_d;
  logic                fb_strobe_q, fb_strobe_d;
  logic                fb_lane_out_q, fb_lane_out_d;
  logic                fb_bc0_q, fb_bc0_d;

  logic                eo;
  logic                start_word;
  logic                new_sig;
  logic [CNT_W:0]      fill;

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= W_EMPTY;
      cnt_q         <= '0;
      orbit_pend_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      word_type_q   <= 1'b0;
      slot_q        <= '0;
      word_end_q    <= 1'b0;
      flush_q       <= 1'b0;
      flush_type_q  <= 1'b0;
      flush_fill_q  <= '0;
      header_q      <= 1'b0;
      fb_cnt_q      <= '0;
      fb_lane_q     <= 1'b0;
      fb_sticky_q   <= 1'b0;
      fb_strobe_q   <= 1'b0;
      fb_lane_out_q <= 1'b0;
      fb_bc0_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      orbit_pend_q  <= orbit_pend_d;
      out_valid_q   <= out_valid_d;
      word_type_q   <= word_type_d;
      slot_q        <= slot_d;
      word_end_q    <= word_end_d;
      flush_q       <= flush_d;
      flush_type_q  <= flush_type_d;
      flush_fill_q  <= flush_fill_d;
      header_q      <= header_d;
      fb_cnt_q      <= fb_cnt_d;
      fb_lane_q     <= fb_lane_d;
      fb_sticky_q   <= fb_sticky_d;
      fb_strobe_q   <= fb_strobe_d;
      fb_lane_out_q <= fb_lane_out_d;
      fb_bc0_q      <= fb_bc0_d;
    end
  end

  // Normal-mode packer: next word state and registered placement outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    orbit_pend_d = orbit_pend_q;
    out_valid_d  = 1'b0;
    word_type_d  = word_type_q;
    slot_d       = slot_q;
    word_end_d   = 1'b0;
    flush_d      = 1'b0;
    flush_type_d = flush_type_q;
    flush_fill_d = flush_fill_q;
    header_d     = 1'b0;
    eo           = bus.Orbit | orbit_pend_q;
    start_word   = 1'b0;
    new_sig      = 1'b0;
    fill         = '0;

    if (bus.fallback) begin
      // Partial word is dropped silently; packing restarts after fallback exit.
      state_d      = W_EMPTY;
      cnt_d        = '0;
      orbit_pend_d = 1'b0;
    end else if (!bus.sample_valid) begin
      if (bus.Orbit) orbit_pend_d = 1'b1;
    end else begin
      out_valid_d  = 1'b1;
      header_d     = eo;
      orbit_pend_d = 1'b0;

      // An orbit closes any open word; a signal sample closes a baseline word.
      // A baseline sample never closes a signal word.
      if (state_q != W_EMPTY && (eo || (state_q == W_BASE && !bus.baseline_flag))) begin
        flush_d      = 1'b1;
        flush_type_d = (state_q == W_SIG);
        flush_fill_d = cnt_q;
      end

      start_word = (state_q == W_EMPTY) || flush_d;
      if (start_word) begin
        new_sig = ~bus.baseline_flag;
        slot_d  = '0;
        fill    = (CNT_W+1)'(1);
      end else begin
        new_sig = (state_q == W_SIG);
        slot_d  = cnt_q;
        fill    = {1'b0, cnt_q} + (CNT_W+1)'(1);
      end
      word_type_d = new_sig;

      if (fill == (new_sig ? SIG_N : BASE_N)) begin
        word_end_d = 1'b1;
        state_d    = W_EMPTY;
        cnt_d      = '0;
      end else begin
        state_d = new_sig ? W_SIG : W_BASE;
        cnt_d   = fill[CNT_W-1:0];
      end
    end
  end

  // Fallback cadence: free-running period counter, independent of sample_valid.
  always_comb begin
    fb_cnt_d      = fb_cnt_q;
    fb_lane_d     = fb_lane_q;
    fb_sticky_d   = fb_sticky_q;
    fb_strobe_d   = 1'b0;
    fb_lane_out_d = fb_lane_out_q;
    fb_bc0_d      = 1'b0;

    if (!bus.fallback) begin
      fb_cnt_d      = '0;
      fb_lane_d     = 1'b0;
      fb_sticky_d   = 1'b0;
      fb_lane_out_d = 1'b0;
    end else if (fb_cnt_q == FB_LAST) begin
      // Last clock of the period: a BC0 arriving right now still counts.
      fb_cnt_d      = '0;
      fb_strobe_d   = 1'b1;
      fb_bc0_d      = fb_sticky_q | bus.Orbit_FB;
      fb_lane_out_d = fb_lane_q;
      fb_lane_d     = ~fb_lane_q;
      fb_sticky_d   = 1'b0;
    end else begin
      fb_cnt_d    = fb_cnt_q + FB_CNT_W'(1);
      fb_sticky_d = fb_sticky_q | bus.Orbit_FB;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.word_type  = word_type_q;
  assign bus.slot       = slot_q;
  assign bus.word_end   = word_end_q;
  assign bus.flush      = flush_q;
  assign bus.flush_type = flush_type_q;
  assign bus.flush_fill = flush_fill_q;
  assign bus.header     = header_q;
  assign bus.fb_strobe  = fb_strobe_q;
  assign bus.fb_lane    = fb_lane_out_q;
  assign bus.fb_bc0     = fb_bc0_q;

endmodule
